// File: rtl/gray_seq_pkg.sv
// Shared types and constants for the two-requester Gray-code sequence arbiter.
// Width decode: a 4-bit job width field of 0 selects the full 16-bit code.
package gray_seq_pkg;

  localparam int NUM_REQ = 2;
  localparam int DATA_W  = 16;
  localparam int LEN_W   = 16;
  localparam int BITS_W  = 4;
  localparam int WIDTH_W = 5;

  localparam logic [WIDTH_W-1:0] WIDTH_ZERO_CODE = 5'd16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic logic [WIDTH_W-1:0] decode_width(input logic [BITS_W-1:0] bits);
    return (bits == '0) ? WIDTH_ZERO_CODE : {1'b0, bits};
  endfunction

endpackage

// File: rtl/gray_mask_encode.sv
// Advances the binary beat counter modulo 2^width and returns the Gray code
// of the advanced value; purely combinational.
module gray_mask_encode
  import gray_seq_pkg::*;
#(
  parameter int DATA_W = gray_seq_pkg::DATA_W
) (
  input  logic [DATA_W-1:0]  b,
  input  logic [WIDTH_W-1:0] width,
  output logic [DATA_W-1:0]  b_next,
  output logic [DATA_W-1:0]  gray_next
);

  logic [DATA_W-1:0] mask;

  // Thermometer mask: bit gi is kept when gi lies below the job width.
  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_mask
    localparam int unsigned IDX = gi;
    assign mask[gi] = (IDX < 32'(width));
  end

  assign b_next    = (b + DATA_W'(1)) & mask;
  assign gray_next = b_next ^ (b_next >> 1);

endmodule

// File: rtl/gray_seq_arbiter.sv
// Round-robin arbiter sharing one Gray-code sequence engine between two
// requesters; streams the granted job's codes on a valid/ready port.
module gray_seq_arbiter
  import gray_seq_pkg::*;
#(
  parameter int DATA_W = gray_seq_pkg::DATA_W,
  parameter int LEN_W  = gray_seq_pkg::LEN_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_REQ-1:0]  req_valid,
  output logic [NUM_REQ-1:0]  req_ready,
  input  logic [BITS_W-1:0]   req0_bits,
  input  logic [BITS_W-1:0]   req1_bits,
  input  logic [LEN_W-1:0]    req0_len_m1,
  input  logic [LEN_W-1:0]    req1_len_m1,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_id,
  output logic                out_last,
  output logic                busy
);

  state_t             state_reg, state_next;
  logic               rr_ptr_reg, rr_ptr_next;
  logic [WIDTH_W-1:0] width_reg, width_next;
  logic [DATA_W-1:0]  cnt_reg, cnt_next;
  logic [LEN_W-1:0]   remaining_reg, remaining_next;
  logic               id_reg, id_next;
  logic               out_valid_reg, out_valid_next;
  logic [DATA_W-1:0]  out_data_reg, out_data_next;
  logic               out_last_reg, out_last_next;
  logic               busy_reg, busy_next;

  logic               grant_id;
  logic               accept;
  logic               fire;
  logic [BITS_W-1:0]  sel_bits;
  logic [LEN_W-1:0]   sel_len;
  logic [DATA_W-1:0]  b_next;
  logic [DATA_W-1:0]  gray_next;

  // The pointer only breaks ties; a lone requester is always granted.
  assign grant_id = (&req_valid) ? rr_ptr_reg : req_valid[1];
  assign accept   = (state_reg == ST_IDLE) && (|req_valid) && !rst;
  assign fire     = out_valid_reg && out_ready;
  assign sel_bits = grant_id ? req1_bits : req0_bits;
  assign sel_len  = grant_id ? req1_len_m1 : req0_len_m1;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
    assign req_ready[gi] = accept && (grant_id == 1'(gi));
  end

  gray_mask_encode #(.DATA_W(DATA_W)) u_encode (
    .b         (cnt_reg),
    .width     (width_reg),
    .b_next    (b_next),
    .gray_next (gray_next)
  );

  always_comb begin
    state_next     = state_reg;
    rr_ptr_next    = rr_ptr_reg;
    width_next     = width_reg;
    cnt_next       = cnt_reg;
    remaining_next = remaining_reg;
    id_next        = id_reg;
    out_valid_next = out_valid_reg;
    out_data_next  = out_data_reg;
    out_last_next  = out_last_reg;
    busy_next      = busy_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          state_next     = ST_RUN;
          width_next     = decode_width(sel_bits);
          cnt_next       = '0;
          remaining_next = sel_len;
          id_next        = grant_id;
          out_valid_next = 1'b1;
          out_data_next  = '0;
          out_last_next  = (sel_len == '0);
          busy_next      = 1'b1;
        end
      end
      ST_RUN: begin
        if (fire) begin
          if (out_last_reg) begin
            state_next     = ST_IDLE;
            rr_ptr_next    = ~id_reg;
            out_valid_next = 1'b0;
            out_last_next  = 1'b0;
            busy_next      = 1'b0;
          end else begin
            // The registered code always tracks the registered counter.
            cnt_next       = b_next;
            remaining_next = remaining_reg - LEN_W'(1);
            out_data_next  = gray_next;
            out_last_next  = (remaining_reg == LEN_W'(1));
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      rr_ptr_reg    <= 1'b0;
      width_reg     <= '0;
      cnt_reg       <= '0;
      remaining_reg <= '0;
      id_reg        <= 1'b0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_last_reg  <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      rr_ptr_reg    <= rr_ptr_next;
      width_reg     <= width_next;
      cnt_reg       <= cnt_next;
      remaining_reg <= remaining_next;
      id_reg        <= id_next;
      out_valid_reg <= out_valid_next;
      out_data_reg  <= out_data_next;
      out_last_reg  <= out_last_next;
      busy_reg      <= busy_next;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_id    = id_reg;
  assign out_last  = out_last_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_gray_seq_arbiter.sv
// Bench for gray_seq_arbiter: job-level reference model checked every cycle,
// directed scenarios pinned to literal code sequences, then random traffic.
module tb_gray_seq_arbiter;
  import gray_seq_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [3:0]         req0_bits, req1_bits;
  logic [LEN_W-1:0]   req0_len_m1, req1_len_m1;
  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  out_data;
  logic               out_id;
  logic               out_last;
  logic               busy;

  int vectors = 0;
  int miscompares = 0;

  // Job-level model: which job runs, its beat index, and the tie-break pointer.
  bit m_run = 1'b0;
  bit m_rr  = 1'b0;
  bit m_id  = 1'b0;
  int m_w   = 1;
  int m_len = 0;
  int m_idx = 0;

  bit hold_req = 1'b0;
  bit auto_req = 1'b0;

  int got_q[$];
  int got_id_q[$];
  int got_last_q[$];

  always #5 clk = ~clk;

  gray_seq_arbiter #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req0_bits   (req0_bits),
    .req1_bits   (req1_bits),
    .req0_len_m1 (req0_len_m1),
    .req1_len_m1 (req1_len_m1),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_id      (out_id),
    .out_last    (out_last),
    .busy        (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Beat i of a W-bit job is the Gray code of i reduced modulo 2^W.
  function automatic int gray_of(input int idx, input int w);
    int v;
    v = idx % (1 << w);
    return v ^ (v >> 1);
  endfunction

  function automatic int model_grant();
    if (req_valid == 2'b11) return int'(m_rr);
    return req_valid[1] ? 1 : 0;
  endfunction

  task automatic compare_now();
    logic [1:0] exp_rdy;
    exp_rdy = 2'b00;
    if (!m_run && req_valid != 2'b00) exp_rdy[model_grant()] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    check("req_ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
    check("busy", 32'(busy), 32'(m_run));
    check("out_valid", 32'(out_valid), 32'(m_run));
    if (m_run) begin
      check("out_data", 32'(out_data), 32'(gray_of(m_idx, m_w)));
      check("out_id", 32'(out_id), 32'(m_id));
      check("out_last", 32'(out_last), 32'(m_idx == m_len));
    end
  endtask

  task automatic randomize_fields(input int r);
    logic [3:0]       bits;
    logic [LEN_W-1:0] len;
    bits = 4'($urandom_range(15));
    len  = ($urandom_range(9) == 0) ? LEN_W'($urandom_range(40)) : LEN_W'($urandom_range(10));
    if (r == 0) begin
      req0_bits = bits; req0_len_m1 = len;
    end else begin
      req1_bits = bits; req1_len_m1 = len;
    end
  endtask

  // One clock: compare at the falling edge, advance the model at the rising
  // edge, then drive the next inputs just after it.
  task automatic step();
    int g;
    bit acc;
    acc = 1'b0;
    g = 0;
    @(negedge clk);
    compare_now();
    if (out_valid && out_ready) begin
      got_q.push_back(int'(out_data));
      if (out_last) begin
        got_id_q.push_back(int'(out_id));
        got_last_q.push_back(got_q.size() - 1);
        $display("job done: id=%0d last_code=0x%0h t=%0t", out_id, out_data, $time);
      end
    end
    @(posedge clk);
    if (!m_run) begin
      if (req_valid != 2'b00) begin
        g     = model_grant();
        acc   = 1'b1;
        m_run = 1'b1;
        m_id  = g[0];
        m_w   = (g == 0) ? ((req0_bits == 0) ? 16 : int'(req0_bits))
                         : ((req1_bits == 0) ? 16 : int'(req1_bits));
        m_len = (g == 0) ? int'(req0_len_m1) : int'(req1_len_m1);
        m_idx = 0;
      end
    end else if (out_ready) begin
      if (m_idx == m_len) begin
        m_run = 1'b0;
        m_rr  = ~m_id;
      end else begin
        m_idx++;
      end
    end
    #1;
    if (acc && !hold_req) begin
      req_valid[g] = 1'b0;
      randomize_fields(g);
    end
    if (auto_req) begin
      for (int r = 0; r < 2; r++) begin
        if (!req_valid[r] && $urandom_range(2) == 0) begin
          randomize_fields(r);
          req_valid[r] = 1'b1;
        end
      end
      out_ready = ($urandom_range(3) != 0);
    end
  endtask

  task automatic drain();
    req_valid = 2'b00;
    out_ready = 1'b1;
    repeat (60) step();
  endtask

  task automatic clear_got();
    got_q.delete();
    got_id_q.delete();
    got_last_q.delete();
  endtask

  // Expected codes packed as nibbles, entry 0 in the least significant nibble.
  task automatic check_got(input string name, input int n, input logic [63:0] packed_exp);
    check({name, "_count"}, 32'(got_q.size() >= n), 32'd1);
    for (int k = 0; k < n; k++) begin
      if (k < got_q.size())
        check($sformatf("%s[%0d]", name, k), 32'(got_q[k]), 32'(packed_exp[4*k +: 4]));
    end
  endtask

  initial begin
    rst         = 1'b1;
    req_valid   = 2'b11;
    req0_bits   = 4'd1;
    req1_bits   = 4'd1;
    req0_len_m1 = LEN_W'(1);
    req1_len_m1 = LEN_W'(1);
    out_ready   = 1'b1;

    @(posedge clk); #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_id", 32'(out_id), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Both requesters held high: grants alternate 0,1,0 with one idle cycle between.
    clear_got();
    hold_req = 1'b1;
    repeat (9) step();
    hold_req = 1'b0;
    drain();
    check("t3_jobs", 32'(got_id_q.size()), 32'd3);
    if (got_id_q.size() >= 3) begin
      check("t3_grant0", 32'(got_id_q[0]), 32'd0);
      check("t3_grant1", 32'(got_id_q[1]), 32'd1);
      check("t3_grant2", 32'(got_id_q[2]), 32'd0);
    end
    check_got("t3_codes", 6, 64'h101010);

    // 3-bit job, eight beats: full Gray cycle.
    clear_got();
    req0_bits = 4'd3; req0_len_m1 = LEN_W'(7); req_valid = 2'b01; out_ready = 1'b1;
    repeat (12) step();
    check_got("t1_codes", 8, 64'h45762310);
    check("t1_last_count", 32'(got_last_q.size()), 32'd1);
    if (got_last_q.size() >= 1) check("t1_last_pos", 32'(got_last_q[0]), 32'd7);
    if (got_id_q.size() >= 1) check("t1_id", 32'(got_id_q[0]), 32'd0);
    check("t1_busy_after", 32'(busy), 32'd0);

    // 2-bit job, six beats: the counter wraps after four.
    clear_got();
    req1_bits = 4'd2; req1_len_m1 = LEN_W'(5); req_valid = 2'b10;
    repeat (10) step();
    check_got("t2_codes", 6, 64'h102310);
    if (got_last_q.size() >= 1) check("t2_last_pos", 32'(got_last_q[0]), 32'd5);
    if (got_id_q.size() >= 1) check("t2_id", 32'(got_id_q[0]), 32'd1);

    // Backpressure for three cycles while beat 2 (code 3) is presented.
    clear_got();
    req0_bits = 4'd4; req0_len_m1 = LEN_W'(5); req_valid = 2'b01;
    for (int i = 0; i < 13; i++) begin
      if (i == 5) begin
        check("t4_stall_valid", 32'(out_valid), 32'd1);
        check("t4_stall_data", 32'(out_data), 32'd3);
      end
      out_ready = !(i >= 3 && i <= 5);
      step();
    end
    check_got("t4_codes", 6, 64'h762310);
    check("t4_count_exact", 32'(got_q.size()), 32'd6);

    // Width field 0 selects 16-bit codes.
    clear_got();
    req0_bits = 4'd0; req0_len_m1 = LEN_W'(3); req_valid = 2'b01; out_ready = 1'b1;
    repeat (8) step();
    check_got("t5_codes", 4, 64'h2310);

    // Reset during beat 3 of an eight-beat job; the pointer (now 1) must return to 0.
    clear_got();
    req0_bits = 4'd3; req0_len_m1 = LEN_W'(7); req_valid = 2'b01;
    repeat (4) step();
    check("t6_pre_data", 32'(out_data), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_out_valid", 32'(out_valid), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_req_ready", 32'(req_ready), 32'd0);
    m_run = 1'b0;
    m_rr  = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_got();
    req0_bits = 4'd3; req0_len_m1 = LEN_W'(7);
    req1_bits = 4'd2; req1_len_m1 = LEN_W'(1);
    req_valid = 2'b11;
    repeat (14) step();
    check_got("t6_codes", 8, 64'h45762310);
    if (got_id_q.size() >= 2) begin
      check("t6_first_id", 32'(got_id_q[0]), 32'd0);
      check("t6_second_id", 32'(got_id_q[1]), 32'd1);
    end else begin
      check("t6_jobs", 32'(got_id_q.size()), 32'd2);
    end
    drain();

    // Random traffic with random backpressure against the model.
    auto_req = 1'b1;
    repeat (3000) step();
    auto_req = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gray_seq_arbiter.md
# gray_seq_arbiter

Round-robin controller that shares one Gray-code sequence engine between two requesters. Each requester posts a job (code width, beat count). The block grants one job at a time and streams that job's Gray codes on a valid/ready output with a requester tag and a last flag. It sits between the stimulus/control sources and any consumer of `gray_out`-style sequences.

## Interface
Parameters:
- `DATA_W`, 16: output code width; fixed maximum code width.
- `LEN_W`, 16: width of the job length field.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `req_valid`, input, 2: per-requester job request; held until accepted.
- `req_ready`, output, 2: one-hot accept strobe; at most one bit high per cycle.
- `req0_bits`, `req1_bits`, input, 4 each: code width; 1..15 literal, 0 means 16.
- `req0_len_m1`, `req1_len_m1`, input, LEN_W each: number of beats minus 1 (minimum 1 beat).
- `out_valid`, output, 1: a code beat is present.
- `out_ready`, input, 1: consumer accepts the beat.
- `out_data`, output, DATA_W: Gray code, zero-extended above the job width.
- `out_id`, output, 1: requester that owns the beat.
- `out_last`, output, 1: final beat of the job.
- `busy`, output, 1: a job is in progress (state RUN).

## Operation
- States:
  - IDLE: no job. If any `req_valid` is high, grant one requester.
    - `req_ready[g]=1` (combinational, IDLE only).
    - Latch that requester's bits/len fields, `id=g`, binary counter `b=0`.
    - Next state RUN.
  - RUN: emit beats. On `out_valid & out_ready`:
    - If last: next state IDLE, and `rr_ptr = ~id`.
    - Otherwise `b` increments and `remaining` decrements.
- Arbitration:
  - Round-robin pointer `rr_ptr` resets to 0.
  - If both requests are valid, grant `rr_ptr`; otherwise grant the only valid one.
  - The pointer updates only at job completion.
- Code generation:
  - `mask = (1<<W)-1`, where `W = bits==0 ? 16 : bits`.
  - `b_next = (b+1) & mask`, so the counter wraps modulo 2^W when a job has more beats than 2^W.
  - `out_data = b ^ (b>>1)`; it never exceeds `mask`.
- `out_last` = (`remaining == 0`).
- Requester fields are sampled only in the accept cycle. Later changes to them have no effect on the running job.
- No cancel path. A job always runs to `out_last`.

## Timing
- Accept in cycle T (IDLE, `req_ready` high). The first beat is valid in cycle T+1 with `out_data=0`.
- Each beat advances only on handshake. While `out_ready=0`, `out_data`, `out_id` and `out_last` hold stable and `out_valid` stays 1.
- Maximum throughput is one beat per cycle.
- Between jobs there is exactly one IDLE cycle, which is the accept cycle for the next job.
- A job of L+1 beats with `out_ready` held high occupies cycles T+1..T+L+1. The earliest next accept is at T+L+2.
- `out_valid`, `out_data`, `out_id`, `out_last` and `busy` are registered outputs. `req_ready` is combinational from state, `req_valid` and `rr_ptr`.
- Reset values (asynchronous): state IDLE, `rr_ptr=0`, `out_valid=0`, `out_data=0`, `out_id=0`, `out_last=0`, `busy=0`. `req_ready` is forced to 0 while `rst` is high.
- Reset mid-job: `out_valid` drops immediately and the job is discarded. After release, a new job starts from code 0.

## Structure
- Shared package `gray_seq_pkg` holds:
  - state encoding (IDLE, RUN)
  - `NUM_REQ=2`
  - `DATA_W`
  - `LEN_W`
  - the width-decode constant (0 → 16)
- One combinational sub-module, `gray_mask_encode`: takes `b` and `W`, and produces the masked next counter value and the Gray code. The FSM, arbiter and registers stay in the top module.

## Test plan
- req0 with bits=3, len_m1=7, `out_ready=1`: beats 0,1,3,2,6,7,5,4, `out_id=0`, `out_last` on the 8th beat only, `busy` drops the cycle after.
- req1 with bits=2, len_m1=5: beats 0,1,3,2,0,1 (wrap), `out_last` on the 6th beat.
- Both `req_valid` high from reset, each with bits=1, len_m1=1:
  - grants in order req0, req1, req0.
  - exactly one IDLE cycle between jobs.
  - `req_ready` is never two-hot.
- Backpressure: req0 with bits=4, len_m1=5, `out_ready` low for 3 cycles at beat 2: `out_data=3` is held, and the sequence 0,1,3,2,6,7 is emitted with no skipped or duplicated codes.
- bits=0 (16-bit), len_m1=3: beats 0x0000, 0x0001, 0x0003, 0x0002.
- `rst` pulse during beat 3 of an 8-beat job:
  - `out_valid=0` asynchronously.
  - `rr_ptr=0`.
  - A re-posted request completes a full job starting at 0.
